// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and baud codes for the UART transmit path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic [2:0] BAUD_1200   = 3'b000;
    localparam logic [2:0] BAUD_2400   = 3'b001;
    localparam logic [2:0] BAUD_4800   = 3'b010;
    localparam logic [2:0] BAUD_9600   = 3'b011;
    localparam logic [2:0] BAUD_19200  = 3'b100;
    localparam logic [2:0] BAUD_38400  = 3'b101;
    localparam logic [2:0] BAUD_57600  = 3'b110;
    localparam logic [2:0] BAUD_115200 = 3'b111;

    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tick_detect.sv
// rtl/uart_tick_detect.sv - turns each level change of the baud sample-enable into a one-cycle tick
module uart_tick_detect (
    input  logic clk,
    input  logic reset,
    input  logic sample_in,
    output logic tick
);

    logic sample_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_q <= 1'b0;
        end else begin
            sample_q <= sample_in;
        end
    end

    assign tick = sample_in ^ sample_q;

endmodule

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - UART transmit frame sequencer with frame-boundary baud switching
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           cfg_baud_select,
    output logic [2:0]           baud_select,
    input  logic                 sample_in,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_line,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_t          state, state_d;
    logic [3:0]           tick_cnt, tick_cnt_d;
    logic [2:0]           bit_cnt, bit_cnt_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic                 parity, parity_d;
    logic [2:0]           baud_select_d;
    logic                 tx_line_d, tx_ready_d, tx_busy_d, tx_done_d;
    logic                 tick, accept, bit_end;

    uart_tick_detect u_tick_detect (
        .clk       (clk),
        .reset     (reset),
        .sample_in (sample_in),
        .tick      (tick)
    );

    assign accept  = tx_valid & tx_ready;
    assign bit_end = tick && (tick_cnt == TICK_LAST);

    always_comb begin
        state_d       = state;
        tick_cnt_d    = tick_cnt;
        bit_cnt_d     = bit_cnt;
        shift_d       = shift;
        parity_d      = parity;
        baud_select_d = baud_select;
        tx_done_d     = 1'b0;

        if (state != IDLE && tick) begin
            tick_cnt_d = bit_end ? 4'd0 : tick_cnt + 4'd1;
        end

        case (state)
            IDLE: begin
                // Ticks seen while idle (including the tx_done cycle) never carry into a frame.
                tick_cnt_d = 4'd0;
                bit_cnt_d  = 3'd0;
                if (accept) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    parity_d = (^tx_data) ^ (PARITY_ODD != 0);
                end else begin
                    baud_select_d = cfg_baud_select;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift >> 1;
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_d = 3'd0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = 3'd0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_d   = IDLE;
                        bit_cnt_d = 3'd0;
                        tx_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next state so the registered line changes with the state.
        tx_ready_d = (state_d == IDLE);
        tx_busy_d  = (state_d != IDLE);
        case (state_d)
            START:   tx_line_d = 1'b0;
            DATA:    tx_line_d = shift_d[0];
            PARITY:  tx_line_d = parity_d;
            default: tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tick_cnt    <= 4'd0;
            bit_cnt     <= 3'd0;
            shift       <= '0;
            parity      <= 1'b0;
            baud_select <= BAUD_1200;
            tx_line     <= 1'b1;
            tx_ready    <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            state       <= state_d;
            tick_cnt    <= tick_cnt_d;
            bit_cnt     <= bit_cnt_d;
            shift       <= shift_d;
            parity      <= parity_d;
            baud_select <= baud_select_d;
            tx_line     <= tx_line_d;
            tx_ready    <= tx_ready_d;
            tx_busy     <= tx_busy_d;
            tx_done     <= tx_done_d;
        end
    end

endmodule
